// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin and decoded-key bundle between a keyboard receiver and the game top level.
// The master drives the decoded key outputs. The slave drives the raw PS/2 pins.
interface ps2_key_decoder_if;
    logic       i_ps2_clk;
    logic       i_ps2_dat;
    logic [7:0] o_key;
    logic       o_key_ext;
    logic       o_make;
    logic       o_break;
    logic       o_frame_err;

    modport master (
        input  i_ps2_clk,
        input  i_ps2_dat,
        output o_key,
        output o_key_ext,
        output o_make,
        output o_break,
        output o_frame_err
    );

    modport slave (
        output i_ps2_clk,
        output i_ps2_dat,
        input  o_key,
        input  o_key_ext,
        input  o_make,
        input  o_break,
        input  o_frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin sync, clock deglitch, 11-bit framing, and E0/F0 scan-code
// interpretation into a held key code with make/break/error pulses.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic               i_clk,
    input logic               i_rst_n,
    ps2_key_decoder_if.master bus
);
    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1});
    endfunction

    logic                  ps2_clk_p0, ps2_clk_p1, ps2_dat_p0, ps2_dat_p1;
    logic [FILTER_LEN-2:0] filt_sh_p1;
    logic [FILTER_LEN-1:0] filt_win;
    logic                  filt_clk_p2, filt_clk_p3, sample;

    rx_state_t             state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]       to_cnt_q;
    logic                  shift_en, par_en, byte_ok, frame_bad, timeout;
    logic [7:0]            shift_q, byte_p4;
    logic                  parity_q, vld_p4, err_q;

    logic [7:0]            key_q;
    logic                  key_ext_q, make_q, break_q, ext_flag_q, brk_flag_q;

    // Sync and deglitch: the window holds the newest FILTER_LEN synced clock samples
    assign filt_win = {filt_sh_p1, ps2_clk_p1};
    assign sample   = filt_clk_p3 & ~filt_clk_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_dat_p0  <= 1'b1;
            ps2_dat_p1  <= 1'b1;
            filt_sh_p1  <= '1;
            filt_clk_p2 <= 1'b1;
            filt_clk_p3 <= 1'b1;
        end else begin
            ps2_clk_p0  <= bus.i_ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_dat_p0  <= bus.i_ps2_dat;
            ps2_dat_p1  <= ps2_dat_p0;
            filt_sh_p1  <= filt_win[FILTER_LEN-2:0];
            if (filt_win == '0)
                filt_clk_p2 <= 1'b0;
            else if (&filt_win)
                filt_clk_p2 <= 1'b1;
            filt_clk_p3 <= filt_clk_p2;
        end
    end

    // Frame receiver, advancing only on filtered falling edges
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        timeout   = 1'b0;
        if (sample) begin
            case (state_q)
                R_IDLE: begin
                    if (!ps2_dat_p1) begin
                        state_d   = R_DATA;
                        bit_cnt_d = '0;
                    end
                end
                R_DATA: begin
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = R_PARITY;
                end
                R_PARITY: begin
                    par_en  = 1'b1;
                    state_d = R_STOP;
                end
                R_STOP: begin
                    if (ps2_dat_p1 && (^{shift_q, parity_q}))
                        byte_ok = 1'b1;
                    else
                        frame_bad = 1'b1;
                    state_d = R_IDLE;
                end
            endcase
        end else if (state_q != R_IDLE && to_cnt_q == TO_MAX) begin
            timeout = 1'b1;
            state_d = R_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= R_IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            vld_p4    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            if (sample || state_q == R_IDLE)
                to_cnt_q <= '0;
            else if (to_cnt_q != TO_MAX)
                to_cnt_q <= to_cnt_q + 1'b1;
            vld_p4    <= byte_ok;
            err_q     <= frame_bad | timeout;
        end
    end

    always_ff @(posedge i_clk) begin
        if (shift_en)
            shift_q <= {ps2_dat_p1, shift_q[7:1]};
        if (par_en)
            parity_q <= ps2_dat_p1;
        if (byte_ok)
            byte_p4 <= shift_q;
    end

    // Scan-code interpreter, one cycle after the stop bit is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_q      <= 8'h00;
            key_ext_q  <= 1'b0;
            make_q     <= 1'b0;
            break_q    <= 1'b0;
            ext_flag_q <= 1'b0;
            brk_flag_q <= 1'b0;
        end else begin
            make_q  <= 1'b0;
            break_q <= 1'b0;
            if (timeout) begin
                ext_flag_q <= 1'b0;
                brk_flag_q <= 1'b0;
            end else if (vld_p4) begin
                if (byte_p4 == 8'hE0) begin
                    ext_flag_q <= 1'b1;
                end else if (byte_p4 == 8'hF0) begin
                    brk_flag_q <= 1'b1;
                end else begin
                    ext_flag_q <= 1'b0;
                    brk_flag_q <= 1'b0;
                    if (!is_ignored(byte_p4)) begin
                        if (brk_flag_q) begin
                            break_q <= 1'b1;
                            if (byte_p4 == key_q && ext_flag_q == key_ext_q) begin
                                key_q     <= 8'h00;
                                key_ext_q <= 1'b0;
                            end
                        end else begin
                            key_q     <= byte_p4;
                            key_ext_q <= ext_flag_q;
                            make_q    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.o_key       = key_q;
    assign bus.o_key_ext   = key_ext_q;
    assign bus.o_make      = make_q;
    assign bus.o_break     = break_q;
    assign bus.o_frame_err = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: frames are driven on the pins while a scoreboard of expected
// make/break/error events is checked by an independent monitor.
module tb_ps2_key_decoder;
    localparam int FL = 8;
    localparam int TO = 3000;
    localparam int K_MAKE  = 0;
    localparam int K_BREAK = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int         kind;
        logic [7:0] key;
        logic       ext;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    ps2_key_decoder_if bus();

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         stop_fall_cyc = 0;
    logic [7:0] m_key;
    logic       m_ext, m_eflag, m_bflag;
    logic [7:0] ign_tab [7] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_key = 8'h00; m_ext = 1'b0; m_eflag = 1'b0; m_bflag = 1'b0;
    endtask

    task automatic expect_ev(input int kind);
        exp_t e;
        e.kind = kind; e.key = m_key; e.ext = m_ext;
        sb.push_back(e);
    endtask

    // Reference: what a keyboard byte stream means to the game, one byte at a time
    task automatic model_byte(input logic [7:0] b);
        bit ign;
        ign = 1'b0;
        foreach (ign_tab[i]) if (ign_tab[i] == b) ign = 1'b1;
        if (b == 8'hE0) m_eflag = 1'b1;
        else if (b == 8'hF0) m_bflag = 1'b1;
        else if (ign) begin
            m_eflag = 1'b0; m_bflag = 1'b0;
        end else if (m_bflag) begin
            if (b == m_key && m_eflag == m_ext) begin
                m_key = 8'h00; m_ext = 1'b0;
            end
            expect_ev(K_BREAK);
            m_eflag = 1'b0; m_bflag = 1'b0;
        end else begin
            m_key = b; m_ext = m_eflag;
            expect_ev(K_MAKE);
            m_eflag = 1'b0; m_bflag = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int hp);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.i_ps2_dat = fr[i];
            repeat (hp) @(negedge clk);
            bus.i_ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            repeat (hp) @(negedge clk);
            bus.i_ps2_clk = 1'b1;
        end
        bus.i_ps2_dat = 1'b1;
        repeat (2 * hp) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hp);
        model_byte(b);
        send_frame(b, 1'b0, 1'b0, 11, hp);
    endtask

    exp_t mon_e;
    int   mon_k;
    int   mon_lat;

    always @(negedge clk) begin
        if (rst_n && (bus.o_make || bus.o_break || bus.o_frame_err)) begin
            mon_k = bus.o_make ? K_MAKE : (bus.o_break ? K_BREAK : K_ERR);
            checks++;
            if ($countones({bus.o_make, bus.o_break, bus.o_frame_err}) > 1) begin
                errors++;
                $display("FAIL pulse_exclusive make=%0b break=%0b err=%0b required one",
                         bus.o_make, bus.o_break, bus.o_frame_err);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse kind=%0d key=%h ext=%0b required none",
                         mon_k, bus.o_key, bus.o_key_ext);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind != mon_k || bus.o_key !== mon_e.key || bus.o_key_ext !== mon_e.ext) begin
                    errors++;
                    $display("FAIL event kind=%0d key=%h ext=%0b required kind=%0d key=%h ext=%0b",
                             mon_k, bus.o_key, bus.o_key_ext, mon_e.kind, mon_e.key, mon_e.ext);
                end
                if (mon_k != K_ERR) begin
                    checks++;
                    mon_lat = cyc - stop_fall_cyc;
                    if (mon_lat < 1 || mon_lat > FL + 4) begin
                        errors++;
                        $display("FAIL latency cycles=%0d required 1..%0d", mon_lat, FL + 4);
                    end
                end
            end
        end
    end

    initial begin
        int         hp, act;
        logic [7:0] code, hk;
        logic       he;
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        chk("rst_key", bus.o_key, 8'h00);
        chk("rst_ext", bus.o_key_ext, 1'b0);
        chk("rst_pulses", {bus.o_make, bus.o_break, bus.o_frame_err}, 3'b000);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        send_byte(8'h5A, 200);
        chk("t1_make_key", bus.o_key, 8'h5A);
        chk("t1_make_ext", bus.o_key_ext, 1'b0);
        send_byte(8'hF0, 200);
        send_byte(8'h5A, 200);
        chk("t1_break_key", bus.o_key, 8'h00);

        send_byte(8'hE0, 25);
        send_byte(8'h75, 25);
        chk("t2_make", {bus.o_key_ext, bus.o_key}, {1'b1, 8'h75});
        send_byte(8'hE0, 25);
        send_byte(8'hF0, 25);
        send_byte(8'h75, 25);
        chk("t2_break", {bus.o_key_ext, bus.o_key}, {1'b0, 8'h00});

        send_byte(8'hE0, 25); send_byte(8'h75, 25);
        chk("t3_first", bus.o_key, 8'h75);
        send_byte(8'hE0, 25); send_byte(8'h72, 25);
        chk("t3_second", bus.o_key, 8'h72);
        send_byte(8'hE0, 25); send_byte(8'hF0, 25); send_byte(8'h75, 25);
        chk("t3_held", {bus.o_key_ext, bus.o_key}, {1'b1, 8'h72});
        send_byte(8'hE0, 25); send_byte(8'hF0, 25); send_byte(8'h72, 25);

        expect_ev(K_ERR);
        send_frame(8'h5A, 1'b1, 1'b0, 11, 25);
        expect_ev(K_ERR);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 25);
        chk("t4_key_kept", bus.o_key, 8'h00);

        expect_ev(K_ERR);
        m_eflag = 1'b0; m_bflag = 1'b0;
        send_frame(8'h00, 1'b0, 1'b0, 4, 25);
        repeat (TO + 100) @(negedge clk);
        chk("t5_err_seen", sb.size(), 0);
        send_byte(8'h1C, 25);
        chk("t5_after", bus.o_key, 8'h1C);

        bus.i_ps2_dat = 1'b0;
        bus.i_ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        repeat (50) @(negedge clk);
        send_byte(8'h5A, 25);
        chk("t6_glitch", bus.o_key, 8'h5A);
        send_frame(8'h76, 1'b0, 1'b0, 5, 25);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_rst", bus.o_key, 8'h00);
        chk("t6_sb_empty", sb.size(), 0);
        model_reset();
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h76, 25);
        chk("t6_after_rst", bus.o_key, 8'h76);

        for (int it = 0; it < 40; it++) begin
            hp   = $urandom_range(20, 40);
            act  = $urandom_range(0, 9);
            code = 8'($urandom_range(1, 127));
            hk   = m_key;
            he   = m_ext;
            if (act <= 3) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'hE0, hp);
                send_byte(code, hp);
            end else if (act <= 5) begin
                if (he) send_byte(8'hE0, hp);
                send_byte(8'hF0, hp);
                send_byte((hk != 8'h00) ? hk : code, hp);
            end else if (act == 6) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'hE0, hp);
                send_byte(8'hF0, hp);
                send_byte(code, hp);
            end else if (act == 7) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'hF0, hp);
                send_byte(ign_tab[$urandom_range(0, 6)], hp);
            end else begin
                expect_ev(K_ERR);
                send_frame(code, act == 8, act == 9, 11, hp);
            end
            chk("rand_key", {bus.o_key_ext, bus.o_key}, {m_ext, m_key});
        end

        repeat (200) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
